// File: rtl/msdap_pkg.sv
// Shared types and constants for the calculation-engine channel scheduler.
package msdap_pkg;

    localparam int RESULT_W     = 40;
    localparam int COEFF_BANK_W = 9;
    localparam int RJ_BANK_W    = 4;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_CAPT,
        ST_PUB
    } sched_state_e;

endpackage

// File: rtl/sched_watchdog.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module sched_watchdog #(
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/calc_channel_scheduler.sv
// Time-shares one calculation engine between left and right channels and publishes the
// stereo result pair.
//
// state | meaning
// IDLE  | engine held in reset, waiting for a sample
// HOLD  | engine held in reset for RST_HOLD cycles before a channel run
// RUN   | engine released, waiting for done or timeout
// CAPT  | one cycle with engine back in reset; switch to right or go publish
// PUB   | one cycle publishing the pair; chain straight into a pending sample
module calc_channel_scheduler
    import msdap_pkg::*;
#(
    parameter int RESULT_W = msdap_pkg::RESULT_W,
    parameter int IDX_W    = 8,
    parameter int RST_HOLD = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                sClk,
    input  logic                reset_n,
    input  logic                sampleValid,
    input  logic [IDX_W-1:0]    dataIndex,
    input  logic                calcDone,
    input  logic [RESULT_W-1:0] calcResult,
    input  logic [9:0]          engCoeffIndex,
    input  logic [4:0]          engRjIndex,
    output logic                calcReset_n,
    output logic [IDX_W-1:0]    dataIndexOut,
    output logic                activeCh,
    output logic [9:0]          coeffAddr,
    output logic [4:0]          rjAddr,
    output logic [RESULT_W-1:0] outL,
    output logic [RESULT_W-1:0] outR,
    output logic                outValid,
    output logic                busy,
    output logic                overrun,
    output logic                timeoutErr
);

    localparam int CNT_MAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);

    sched_state_e        r_state;
    logic                r_calc_reset_n;
    logic [IDX_W-1:0]    r_data_idx;
    logic                r_active_ch;
    logic [RESULT_W-1:0] r_out_l;
    logic [RESULT_W-1:0] r_out_r;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_overrun;
    logic                r_timeout_err;
    logic                r_pending;
    logic [IDX_W-1:0]    r_pend_idx;
    logic [RESULT_W-1:0] r_stage_l;
    logic [RESULT_W-1:0] r_stage_r;

    logic                w_launch;
    logic [IDX_W-1:0]    w_next_idx;
    logic                w_wd_load;
    logic [CNT_W-1:0]    w_wd_val;
    logic                w_wd_expired;
    logic                w_unused_bits;

    // A strobe arriving in the launch cycle is newer than any stored pending index.
    assign w_launch   = sampleValid || r_pending;
    assign w_next_idx = sampleValid ? dataIndex : r_pend_idx;

    always_comb begin
        w_wd_load = 1'b0;
        w_wd_val  = HOLD_LOAD;
        case (r_state)
            ST_IDLE, ST_PUB: w_wd_load = w_launch;
            ST_CAPT:         w_wd_load = (r_active_ch == CH_LEFT);
            ST_HOLD: begin
                w_wd_load = w_wd_expired;
                w_wd_val  = TO_LOAD;
            end
            default: ;
        endcase
    end

    sched_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .i_clk      (sClk),
        .i_rst_n    (reset_n),
        .i_load     (w_wd_load),
        .i_load_val (w_wd_val),
        .o_expired  (w_wd_expired)
    );

    always_ff @(posedge sClk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_calc_reset_n <= 1'b0;
            r_data_idx     <= '0;
            r_active_ch    <= CH_LEFT;
            r_out_l        <= '0;
            r_out_r        <= '0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_pending      <= 1'b0;
            r_pend_idx     <= '0;
            r_stage_l      <= '0;
            r_stage_r      <= '0;
        end else begin
            r_out_valid <= 1'b0;

            if (sampleValid && (r_state != ST_IDLE)) begin
                r_pending  <= 1'b1;
                r_pend_idx <= dataIndex;
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_data_idx  <= w_next_idx;
                        r_active_ch <= CH_LEFT;
                        r_pending   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_wd_expired) begin
                        r_calc_reset_n <= 1'b1;
                        r_state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Latch at the done edge: the engine is back in reset during CAPT.
                    if (calcDone || w_wd_expired) begin
                        if (r_active_ch == CH_LEFT) begin
                            r_stage_l <= calcDone ? calcResult : '0;
                        end else begin
                            r_stage_r <= calcDone ? calcResult : '0;
                        end
                        if (!calcDone) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_calc_reset_n <= 1'b0;
                        r_state        <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (r_active_ch == CH_LEFT) begin
                        r_active_ch <= CH_RIGHT;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_state <= ST_PUB;
                    end
                end
                ST_PUB: begin
                    r_out_l     <= r_stage_l;
                    r_out_r     <= r_stage_r;
                    r_out_valid <= 1'b1;
                    if (w_launch) begin
                        r_data_idx  <= w_next_idx;
                        r_active_ch <= CH_LEFT;
                        r_pending   <= 1'b0;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The engine's upper index bits wrap within a bank and are deliberately dropped.
    assign w_unused_bits = engCoeffIndex[9] ^ engRjIndex[4];
    assign coeffAddr     = {r_active_ch, engCoeffIndex[COEFF_BANK_W-1:0]};
    assign rjAddr        = {r_active_ch, engRjIndex[RJ_BANK_W-1:0]};

    assign calcReset_n  = r_calc_reset_n;
    assign dataIndexOut = r_data_idx;
    assign activeCh     = r_active_ch;
    assign outL         = r_out_l;
    assign outR         = r_out_r;
    assign outValid     = r_out_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;
    assign timeoutErr   = r_timeout_err;

endmodule

// File: tb/tb_calc_channel_scheduler.sv
// Self-checking bench for calc_channel_scheduler: vector table, timeline-model schedules,
// randomized strobe patterns and a mid-run reset.
module tb_calc_channel_scheduler;

    localparam int RW = 40;
    localparam int IW = 8;
    localparam int RH = 2;
    localparam int TO = 4096;

    logic          sClk = 1'b0;
    logic          reset_n = 1'b1;
    logic          sampleValid = 1'b0;
    logic [IW-1:0] dataIndex = '0;
    logic          calcDone;
    logic [RW-1:0] calcResult;
    logic [9:0]    engCoeffIndex = 10'h3FF;
    logic [4:0]    engRjIndex = 5'h1F;
    logic          calcReset_n;
    logic [IW-1:0] dataIndexOut;
    logic          activeCh;
    logic [9:0]    coeffAddr;
    logic [4:0]    rjAddr;
    logic [RW-1:0] outL, outR;
    logic          outValid, busy, overrun, timeoutErr;

    int errors = 0;
    int checks = 0;

    int            eng_t = 10;
    bit            eng_hang_l = 1'b0;
    bit            eng_fixed = 1'b0;
    logic [RW-1:0] fix_l = '0;
    logic [RW-1:0] fix_r = '0;
    int            eng_cnt = 0;

    int            s_t[$];
    logic [IW-1:0] s_idx[$];

    typedef struct {
        logic [IW-1:0] idx;
        int            t;
        bit            hang_l;
        logic [RW-1:0] res_l;
        logic [RW-1:0] res_r;
        logic [RW-1:0] exp_l;
        logic [RW-1:0] exp_r;
        int            exp_lat;
        bit            exp_to;
        bit            chk_addr;
    } vec_t;
    vec_t vecs[4];

    always #5 sClk = ~sClk;

    calc_channel_scheduler #(
        .RESULT_W(RW), .IDX_W(IW), .RST_HOLD(RH), .TIMEOUT(TO)
    ) dut (
        .sClk(sClk), .reset_n(reset_n), .sampleValid(sampleValid), .dataIndex(dataIndex),
        .calcDone(calcDone), .calcResult(calcResult), .engCoeffIndex(engCoeffIndex),
        .engRjIndex(engRjIndex), .calcReset_n(calcReset_n), .dataIndexOut(dataIndexOut),
        .activeCh(activeCh), .coeffAddr(coeffAddr), .rjAddr(rjAddr), .outL(outL),
        .outR(outR), .outValid(outValid), .busy(busy), .overrun(overrun),
        .timeoutErr(timeoutErr)
    );

    function automatic logic [RW-1:0] res_hash(input logic [IW-1:0] idx, input logic ch);
        logic [23:0] lo;
        lo = 24'(idx) * 24'd40503 + 24'h135;
        return {(ch ? 8'hC3 : 8'h3C), idx, lo};
    endfunction

    // Engine model: done on the eng_t-th cycle out of reset; result depends on index and channel.
    always @(posedge sClk) begin
        if (!calcReset_n) eng_cnt <= 0;
        else              eng_cnt <= eng_cnt + 1;
    end
    assign calcDone   = calcReset_n && !(eng_hang_l && !activeCh) && (eng_cnt == eng_t - 1);
    assign calcResult = eng_fixed ? (activeCh ? fix_r : fix_l) : res_hash(dataIndexOut, activeCh);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, 64'({calcReset_n, activeCh, dataIndexOut, outValid, busy, overrun,
                                  timeoutErr}), 64'd0);
        chk({tag, "_outL"}, 64'(outL), 64'd0);
        chk({tag, "_outR"}, 64'(outR), 64'd0);
        chk({tag, "_coeff"}, 64'(coeffAddr), 64'h1FF);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sClk);
        sampleValid = 1'b0;
        reset_n = 1'b0;
        #1 check_reset(tag);
        @(negedge sClk);
        @(negedge sClk);
        reset_n = 1'b1;
        @(negedge sClk);
    endtask

    // Timeline model: a strobe on an idle block starts a sequence that publishes 7+2T edges later;
    // strobes during a sequence (including its publish edge) collapse into one pending sample.
    task automatic run_sched(input string name, input int t);
        int            q_start[$];
        int            q_pub[$];
        logic [IW-1:0] q_idx[$];
        int            obs_n[$];
        logic [RW-1:0] obs_l[$];
        logic [RW-1:0] obs_r[$];
        bit            m_ov, act, pend, exp_busy;
        int            cs, cp, horizon, j, busy_bad, idx_bad;
        logic [IW-1:0] ci, pidx, exp_idx;
        m_ov = 0; act = 0; pend = 0; cs = 0; cp = 0; ci = '0; pidx = '0;
        busy_bad = 0; idx_bad = 0; j = 0;
        eng_t = t; eng_fixed = 0; eng_hang_l = 0;
        for (int i = 0; i <= s_t.size(); i++) begin
            while (act && (i == s_t.size() || s_t[i] > cp)) begin
                q_start.push_back(cs); q_pub.push_back(cp); q_idx.push_back(ci);
                if (pend) begin
                    cs = cp; cp = cp + 7 + 2 * t; ci = pidx; pend = 0;
                end else begin
                    act = 0;
                end
            end
            if (i < s_t.size()) begin
                if (!act) begin
                    act = 1; cs = s_t[i]; cp = s_t[i] + 7 + 2 * t; ci = s_idx[i];
                end else begin
                    if (pend) m_ov = 1;
                    pend = 1; pidx = s_idx[i];
                end
            end
        end
        horizon = q_pub[q_pub.size() - 1] + 4;
        for (int n = 0; n <= horizon; n++) begin
            @(negedge sClk);
            if (n > 0) begin
                if (outValid) begin
                    obs_n.push_back(n); obs_l.push_back(outL); obs_r.push_back(outR);
                end
                exp_busy = 0; exp_idx = '0;
                foreach (q_start[k]) begin
                    if (n >= q_start[k] + 1 && n <= q_pub[k]) begin
                        exp_busy = 1; exp_idx = q_idx[k];
                    end
                end
                if (busy !== exp_busy) busy_bad++;
                if (exp_busy && dataIndexOut !== exp_idx) idx_bad++;
            end
            if (j < s_t.size() && s_t[j] == n) begin
                sampleValid = 1'b1; dataIndex = s_idx[j]; j++;
            end else begin
                sampleValid = 1'b0; dataIndex = IW'($urandom);
            end
        end
        sampleValid = 1'b0;
        chk({name, "_pub_count"}, 64'(obs_n.size()), 64'(q_pub.size()));
        for (int k = 0; k < q_pub.size() && k < obs_n.size(); k++) begin
            chk({name, "_pub_time"}, 64'(obs_n[k]), 64'(q_pub[k] + 1));
            chk({name, "_outL"}, 64'(obs_l[k]), 64'(res_hash(q_idx[k], 1'b0)));
            chk({name, "_outR"}, 64'(obs_r[k]), 64'(res_hash(q_idx[k], 1'b1)));
        end
        chk({name, "_overrun"}, 64'(overrun), 64'(m_ov));
        chk({name, "_busy_cycles_bad"}, 64'(busy_bad), 64'd0);
        chk({name, "_index_cycles_bad"}, 64'(idx_bad), 64'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int            lat, idx_bad, nv, nb, tt;
    bit            got;
    logic [RW-1:0] got_l, got_r;

    initial begin
        vecs[0] = '{idx: 8'd5, t: 100, hang_l: 0, res_l: 40'h12_3456_789A, res_r: 40'h1,
                    exp_l: 40'h12_3456_789A, exp_r: 40'h1, exp_lat: 208, exp_to: 0, chk_addr: 1};
        vecs[1] = '{idx: 8'hFF, t: 1, hang_l: 0, res_l: 40'hFF_FFFF_FFFF, res_r: 40'h80_0000_0000,
                    exp_l: 40'hFF_FFFF_FFFF, exp_r: 40'h80_0000_0000, exp_lat: 10, exp_to: 0,
                    chk_addr: 0};
        vecs[2] = '{idx: 8'd0, t: 7, hang_l: 0, res_l: 40'hA5_A5A5_A5A5, res_r: 40'h5A_5A5A_5A5A,
                    exp_l: 40'hA5_A5A5_A5A5, exp_r: 40'h5A_5A5A_5A5A, exp_lat: 22, exp_to: 0,
                    chk_addr: 0};
        vecs[3] = '{idx: 8'd9, t: 10, hang_l: 1, res_l: 40'hDE_ADBE_EF00, res_r: 40'h77,
                    exp_l: 40'h0, exp_r: 40'h77, exp_lat: 4114, exp_to: 1, chk_addr: 0};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge sClk);
        check_reset("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge sClk);
        chk("idle_no_activity", 64'({busy, outValid, calcReset_n}), 64'd0);

        foreach (vecs[v]) begin
            eng_t = vecs[v].t; eng_hang_l = vecs[v].hang_l; eng_fixed = 1;
            fix_l = vecs[v].res_l; fix_r = vecs[v].res_r;
            @(negedge sClk);
            sampleValid = 1'b1; dataIndex = vecs[v].idx;
            lat = 0; got = 0; idx_bad = 0; got_l = '0; got_r = '0;
            while (!got && lat < 6000) begin
                @(negedge sClk);
                lat++;
                sampleValid = 1'b0;
                if (outValid) begin
                    got = 1; got_l = outL; got_r = outR;
                end else if (busy && dataIndexOut !== vecs[v].idx) begin
                    idx_bad++;
                end
                if (vecs[v].chk_addr) begin
                    if (lat == 2) chk("hold_reset_low", 64'({calcReset_n, activeCh, busy}), 64'b001);
                    if (lat == 3) chk("run_reset_high", 64'(calcReset_n), 64'd1);
                    if (lat == 5) chk("addr_left", 64'({coeffAddr, rjAddr}), 64'({10'h1FF, 5'd15}));
                    if (lat == 110) chk("addr_right", 64'({coeffAddr, rjAddr}), 64'({10'h3FF, 5'd31}));
                end
                dataIndex = IW'($urandom);
            end
            chk("vec_latency", 64'(lat), 64'(vecs[v].exp_lat));
            chk("vec_outL", 64'(got_l), 64'(vecs[v].exp_l));
            chk("vec_outR", 64'(got_r), 64'(vecs[v].exp_r));
            chk("vec_index_frozen_bad", 64'(idx_bad), 64'd0);
            chk("vec_timeoutErr", 64'(timeoutErr), 64'(vecs[v].exp_to));
            chk("vec_overrun", 64'(overrun), 64'd0);
            @(negedge sClk);
            chk("vec_single_strobe", 64'({outValid, busy}), 64'd0);
            chk("vec_outL_held", 64'(outL), 64'(vecs[v].exp_l));
        end

        // Pending sample during the left run chains without an idle cycle.
        do_reset("t3");
        s_t.delete(); s_idx.delete();
        s_t.push_back(0);  s_idx.push_back(8'd10);
        s_t.push_back(12); s_idx.push_back(8'd6);
        run_sched("pending", 20);

        // Strobe exactly in the publish cycle is kept.
        do_reset("t3b");
        s_t.delete(); s_idx.delete();
        s_t.push_back(0);  s_idx.push_back(8'h11);
        s_t.push_back(47); s_idx.push_back(8'h22);
        run_sched("pub_cycle_strobe", 20);

        // Three strobes inside one sequence: overrun, newest index wins.
        do_reset("t4");
        s_t.delete(); s_idx.delete();
        s_t.push_back(0);  s_idx.push_back(8'd3);
        s_t.push_back(10); s_idx.push_back(8'd6);
        s_t.push_back(20); s_idx.push_back(8'd7);
        s_t.push_back(30); s_idx.push_back(8'd8);
        run_sched("overrun", 20);

        for (int r = 0; r < 8; r++) begin
            do_reset("rand");
            s_t.delete(); s_idx.delete();
            eng_t = int'($urandom_range(1, 12));
            tt = int'($urandom_range(0, 3));
            for (int s = 0; s < int'($urandom_range(2, 8)); s++) begin
                s_t.push_back(tt); s_idx.push_back(IW'($urandom));
                tt = tt + int'($urandom_range(1, 4 * eng_t + 12));
            end
            run_sched("random", eng_t);
        end

        // Reset during the right run drops everything.
        do_reset("t6");
        eng_fixed = 0; eng_hang_l = 0; eng_t = 30; nv = 0; nb = 0;
        @(negedge sClk);
        sampleValid = 1'b1; dataIndex = 8'd4;
        for (int n = 1; n <= 50; n++) begin
            @(negedge sClk);
            sampleValid = 1'b0;
            if (outValid) nv++;
        end
        chk("t6_in_right_run", 64'({activeCh, calcReset_n}), 64'b11);
        reset_n = 1'b0;
        #1 check_reset("t6_async");
        repeat (3) @(negedge sClk);
        reset_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge sClk);
            if (outValid) nv++;
            if (busy) nb++;
        end
        chk("t6_no_publish", 64'(nv), 64'd0);
        chk("t6_stays_idle", 64'(nb), 64'd0);
        s_t.delete(); s_idx.delete();
        s_t.push_back(0); s_idx.push_back(8'h42);
        run_sched("t6_after_reset", 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
